ecp5pll_phase_ctrl: RTL and testbench

//  Initiator for the EHXPLLL dynamic phase interface (phasesel/phasedir/phasestep/phaseloadreg).

---
 rtl/ecp5pll_phase_pkg.sv | 23 ++
 rtl/ecp5pll_phase_ctrl_if.sv | 24 ++
 rtl/ecp5pll_phase_track.sv | 52 +++++
 rtl/ecp5pll_phase_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ecp5pll_phase_ctrl.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecp5pll_phase_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL dynamic phase controller.
package ecp5pll_phase_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STEP_HI = 3'd2,
    STEP_LO = 3'd3,
    LOAD_HI = 3'd4,
    LOAD_LO = 3'd5,
    SETTLE  = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic        DIR_LAG  = 1'b0;
  localparam logic        DIR_LEAD = 1'b1;
  localparam int unsigned PHASE_W  = 10;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ecp5pll_phase_ctrl_if.sv
// Request/status handshake between user logic and the phase controller.
interface ecp5pll_phase_ctrl_if #(
  parameter int unsigned STEPS_W = 8
);
  logic               req_valid;
  logic               req_ready;
  logic [1:0]         req_sel;
  logic               req_dir;
  logic [STEPS_W-1:0] req_steps;
  logic               req_load;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output req_valid, req_sel, req_dir, req_steps, req_load,
    input  req_ready, busy, done, err
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps, req_load,
    output req_ready, busy, done, err
  );
endinterface

// File: rtl/ecp5pll_phase_track.sv
// Per-channel phase tracker: four modulo-(div*8) up/down accumulators.
// Only instantiated when ECP5PLL_PHASE_TRACK_EN is defined.
module ecp5pll_phase_track
  import ecp5pll_phase_pkg::*;
#(
  parameter int unsigned div0 = 4,
  parameter int unsigned div1 = 4,
  parameter int unsigned div2 = 4,
  parameter int unsigned div3 = 4
) (
  input  logic                   clk_i,
  input  logic                   reset,
  input  logic                   step_i,
  input  logic [1:0]             sel_i,
  input  logic                   dir_i,
  output logic [4*PHASE_W-1:0]   phase_o
);

  localparam int unsigned DIV [4] = '{div0, div1, div2, div3};

  logic [PHASE_W-1:0] phase_q [4];
  logic [PHASE_W-1:0] phase_d [4];

  always_comb begin
    for (int unsigned ch = 0; ch < 4; ch++) begin
      phase_d[ch] = phase_q[ch];
      if (step_i && (sel_i == 2'(ch))) begin
        if (dir_i == DIR_LAG) begin
          phase_d[ch] = (phase_q[ch] == PHASE_W'(DIV[ch] * 8 - 1)) ? '0
                                                                 : phase_q[ch] + PHASE_W'(1);
        end else begin
          phase_d[ch] = (phase_q[ch] == '0) ? PHASE_W'(DIV[ch] * 8 - 1)
                                            : phase_q[ch] - PHASE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned ch = 0; ch < 4; ch++) begin
      if (reset) phase_q[ch] <= '0;
      else       phase_q[ch] <= phase_d[ch];
    end
  end

  always_comb begin
    for (int unsigned ch = 0; ch < 4; ch++) begin
      phase_o[ch*PHASE_W +: PHASE_W] = phase_q[ch];
    end
  end

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// EHXPLLL dynamic phase initiator: turns one request into timed PHASESTEP/PHASELOADREG
// pulses and waits for lock. Phase tracking is enabled with `ECP5PLL_PHASE_TRACK_EN.
module ecp5pll_phase_ctrl
  import ecp5pll_phase_pkg::*;
#(
  parameter int unsigned setup_cyc   = 2,
  parameter int unsigned pulse_cyc   = 4,
  parameter int unsigned gap_cyc     = 4,
  parameter int unsigned settle_cyc  = 16,
  parameter int unsigned timeout_cyc = 4096,
  parameter int unsigned steps_w     = 8,
  parameter int unsigned div0        = 4,
  parameter int unsigned div1        = 4,
  parameter int unsigned div2        = 4,
  parameter int unsigned div3        = 4
) (
  input  logic                   clk_i,
  input  logic                   reset,
  ecp5pll_phase_ctrl_if.slave    req,
  input  logic                   locked_i,
  output logic [1:0]             phasesel,
  output logic                   phasedir,
  output logic                   phasestep,
  output logic                   phaseloadreg,
  output logic [4*PHASE_W-1:0]   phase_o
);

  localparam int unsigned CNT_MAX = max_u(max_u(setup_cyc, pulse_cyc),
                                          max_u(gap_cyc, settle_cyc + timeout_cyc));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(setup_cyc - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(pulse_cyc - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(gap_cyc - 1);
  localparam logic [CNT_W-1:0] SETTLE_MIN  = CNT_W'(settle_cyc - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(settle_cyc - 1 + timeout_cyc);

  // A misconfigured instance (zero timing or divider that overflows PHASE_W) never accepts.
  localparam bit CFG_OK = (setup_cyc >= 1) && (pulse_cyc >= 1) && (gap_cyc >= 1) &&
                          (settle_cyc >= 1) &&
                          (div0 >= 1) && (div0 * 8 <= (1 << PHASE_W)) &&
                          (div1 >= 1) && (div1 * 8 <= (1 << PHASE_W)) &&
                          (div2 >= 1) && (div2 * 8 <= (1 << PHASE_W)) &&
                          (div3 >= 1) && (div3 * 8 <= (1 << PHASE_W));

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [steps_w-1:0] steps_q, steps_d;
  logic [1:0]         sel_q, sel_d;
  logic               dir_q, dir_d;
  logic               load_q, load_d;
  logic               err_q, err_d;
  logic               accept;

  assign req.req_ready = (state_q == IDLE) && locked_i && !reset && CFG_OK;
  assign accept        = req.req_valid && req.req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    steps_d = steps_q;
    sel_d   = sel_q;
    dir_d   = dir_q;
    load_d  = load_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = SETUP;
          sel_d   = req.req_sel;
          dir_d   = req.req_dir;
          steps_d = req.req_steps;
          load_d  = req.req_load;
          err_d   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d = '0;
          if (steps_q != '0) state_d = STEP_HI;
          else if (load_q)   state_d = LOAD_HI;
          else               state_d = SETTLE;
        end
      end
      STEP_HI: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = STEP_LO;
        end
      end
      STEP_LO: begin
        // steps_q counts the pulses still owed, including the one just finished
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          steps_d = steps_q - steps_w'(1);
          if (steps_q > steps_w'(1)) state_d = STEP_HI;
          else if (load_q)           state_d = LOAD_HI;
          else                       state_d = SETTLE;
        end
      end
      LOAD_HI: begin
        if (cnt_q == PULSE_LAST) begin
          cnt_d   = '0;
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (locked_i && (cnt_q >= SETTLE_MIN)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      steps_q <= '0;
      sel_q   <= '0;
      dir_q   <= DIR_LAG;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = (state_q == STEP_HI);
  assign phaseloadreg = (state_q == LOAD_HI);
  assign req.busy     = (state_q != IDLE);
  assign req.done     = (state_q == DONE);
  assign req.err      = (state_q == DONE) && err_q;

`ifdef ECP5PLL_PHASE_TRACK_EN
  logic step_entry;
  assign step_entry = (state_d == STEP_HI) && (state_q != STEP_HI);

  ecp5pll_phase_track #(
    .div0 (div0),
    .div1 (div1),
    .div2 (div2),
    .div3 (div3)
  ) u_track (
    .clk_i   (clk_i),
    .reset   (reset),
    .step_i  (step_entry),
    .sel_i   (sel_q),
    .dir_i   (dir_q),
    .phase_o (phase_o)
  );
`else
  assign phase_o = '0;
`endif

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Self-checking bench for ecp5pll_phase_ctrl: directed table, lock/timeout/reset corners, random requests.
module tb_ecp5pll_phase_ctrl;

  localparam int unsigned T_SETUP   = 2;
  localparam int unsigned T_PULSE   = 4;
  localparam int unsigned T_GAP     = 4;
  localparam int unsigned T_SETTLE  = 16;
  localparam int unsigned T_TIMEOUT = 4096;
  localparam int unsigned D0 = 4, D1 = 5, D2 = 6, D3 = 3;
  localparam int unsigned DIVS [4] = '{D0, D1, D2, D3};
`ifdef ECP5PLL_PHASE_TRACK_EN
  localparam bit TRACK = 1'b1;
`else
  localparam bit TRACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        locked;
  logic [1:0]  phasesel;
  logic        phasedir, phasestep, phaseloadreg;
  logic [39:0] phase;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned lf = 0, ll = 0;
  int unsigned exp_ph [4];

  always #5 clk = ~clk;

  ecp5pll_phase_ctrl_if #(.STEPS_W(8)) rq ();

  ecp5pll_phase_ctrl #(
    .setup_cyc   (T_SETUP),
    .pulse_cyc   (T_PULSE),
    .gap_cyc     (T_GAP),
    .settle_cyc  (T_SETTLE),
    .timeout_cyc (T_TIMEOUT),
    .steps_w     (8),
    .div0        (D0),
    .div1        (D1),
    .div2        (D2),
    .div3        (D3)
  ) dut (
    .clk_i        (clk),
    .reset        (reset),
    .req          (rq),
    .locked_i     (locked),
    .phasesel     (phasesel),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .phase_o      (phase)
  );

  typedef struct {
    logic [1:0]  sel;
    logic        dir;
    int unsigned steps;
    logic        load;
    int unsigned lf;
    int unsigned ll;
    int unsigned exp_done;
    logic        exp_err;
    int unsigned exp_ph;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Lock is low on sampling edges n in [lf, lf+ll).
  function automatic bit lock_at(input int unsigned n);
    return !((n >= lf) && (n < lf + ll));
  endfunction

  // Done cycle: minimum settle, then first locked sample, else timeout with err.
  task automatic model_done(input int unsigned steps, input logic load,
                            output int unsigned d, output logic e);
    int unsigned base;
    base = 1 + T_SETUP + (steps + (load ? 1 : 0)) * (T_PULSE + T_GAP) + T_SETTLE;
    d = base + T_TIMEOUT;
    e = 1'b1;
    for (int unsigned n = base - 1; n <= base - 1 + T_TIMEOUT; n++) begin
      if (lock_at(n)) begin
        d = n + 1;
        e = 1'b0;
        break;
      end
    end
  endtask

  task automatic model_steps(input logic [1:0] sel, input logic dir, input int unsigned steps);
    int unsigned m;
    m = DIVS[sel] * 8;
    if (TRACK) begin
      repeat (steps) begin
        if (dir == 1'b0) exp_ph[sel] = (exp_ph[sel] + 1) % m;
        else             exp_ph[sel] = (exp_ph[sel] + m - 1) % m;
      end
    end
  endtask

  task automatic issue(input logic [1:0] sel, input logic dir, input int unsigned steps,
                       input logic load);
    @(negedge clk);
    rq.req_sel   = sel;
    rq.req_dir   = dir;
    rq.req_steps = 8'(steps);
    rq.req_load  = load;
    rq.req_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Observes one transaction from the accept edge; cycle n is the value sampled at edge n.
  task automatic complete(input string tag, input logic [1:0] sel, input logic dir,
                          input int unsigned steps, input logic load,
                          input int unsigned exp_done, input logic exp_err);
    int unsigned done_at, s_rise, s_hi, l_rise, l_hi, first_s, first_l;
    int unsigned bad_sel, bad_busy, bad_err;
    logic got_err, ps_prev, pl_prev;
    done_at = 0; s_rise = 0; s_hi = 0; l_rise = 0; l_hi = 0; first_s = 0; first_l = 0;
    bad_sel = 0; bad_busy = 0; bad_err = 0; got_err = 1'b0; ps_prev = 1'b0; pl_prev = 1'b0;
    for (int unsigned n = 1; n <= exp_done + 20 && done_at == 0; n++) begin
      @(negedge clk);
      if (phasestep && !ps_prev) begin s_rise++; if (first_s == 0) first_s = n; end
      if (phaseloadreg && !pl_prev) begin l_rise++; if (first_l == 0) first_l = n; end
      if (phasestep) s_hi++;
      if (phaseloadreg) l_hi++;
      ps_prev = phasestep;
      pl_prev = phaseloadreg;
      if (phasesel != sel || phasedir != dir) bad_sel++;
      if (!rq.busy) bad_busy++;
      if (rq.err && !rq.done) bad_err++;
      if (rq.done) begin
        done_at = n;
        got_err = rq.err;
        locked = 1'b1;
        rq.req_valid = 1'b0;
      end else begin
        locked = lock_at(n);
        rq.req_valid = 1'b1;
        rq.req_sel   = 2'($urandom);
        rq.req_dir   = 1'($urandom);
        rq.req_steps = 8'($urandom);
        rq.req_load  = 1'($urandom);
      end
    end
    locked = 1'b1;
    rq.req_valid = 1'b0;
    check({tag, " done cycle"}, 64'(done_at), 64'(exp_done));
    check({tag, " err"}, 64'(got_err), 64'(exp_err));
    check({tag, " step pulses"}, 64'(s_rise), 64'(steps));
    check({tag, " step high cycles"}, 64'(s_hi), 64'(steps * T_PULSE));
    check({tag, " load pulses"}, 64'(l_rise), 64'(load));
    check({tag, " load high cycles"}, 64'(l_hi), 64'(load ? T_PULSE : 0));
    if (steps > 0) check({tag, " first step cycle"}, 64'(first_s), 64'(1 + T_SETUP));
    if (load) check({tag, " first load cycle"}, 64'(first_l),
                    64'(1 + T_SETUP + steps * (T_PULSE + T_GAP)));
    check({tag, " sel/dir stable"}, 64'(bad_sel), 64'(0));
    check({tag, " busy held"}, 64'(bad_busy), 64'(0));
    check({tag, " err only with done"}, 64'(bad_err), 64'(0));
    @(negedge clk);
    check({tag, " done one cycle"}, 64'(rq.done), 64'(0));
    check({tag, " idle after done"}, 64'(rq.busy), 64'(0));
    check({tag, " ready after done"}, 64'(rq.req_ready), 64'(1));
    for (int unsigned ch = 0; ch < 4; ch++)
      check($sformatf("%s phase ch%0d", tag, ch), 64'(phase[ch*10 +: 10]), 64'(exp_ph[ch]));
  endtask

  vec_t vec [9];

  initial begin
    int unsigned d, rise;
    logic e, prev;
    logic [1:0] s;
    logic dr, ld;
    int unsigned st;

    vec[0] = '{2'd2, 1'b0, 3, 1'b0, 0,  0,    43,   1'b0, 3};
    vec[1] = '{2'd0, 1'b1, 1, 1'b0, 0,  0,    27,   1'b0, 31};
    vec[2] = '{2'd1, 1'b0, 0, 1'b1, 0,  0,    27,   1'b0, 0};
    vec[3] = '{2'd3, 1'b1, 2, 1'b0, 34, 10,   45,   1'b0, 22};
    vec[4] = '{2'd0, 1'b0, 1, 1'b0, 0,  0,    27,   1'b0, 0};
    vec[5] = '{2'd3, 1'b0, 0, 1'b0, 0,  0,    19,   1'b0, 22};
    vec[6] = '{2'd2, 1'b0, 2, 1'b1, 5,  8,    43,   1'b0, 5};
    vec[7] = '{2'd1, 1'b1, 0, 1'b0, 18, 5000, 4115, 1'b1, 0};
    vec[8] = '{2'd3, 1'b0, 2, 1'b1, 0,  0,    43,   1'b0, 0};
    for (int unsigned ch = 0; ch < 4; ch++) exp_ph[ch] = 0;

    reset = 1'b1;
    locked = 1'b1;
    rq.req_valid = 1'b0; rq.req_sel = '0; rq.req_dir = 1'b0; rq.req_steps = '0; rq.req_load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset phasesel", 64'(phasesel), 64'(0));
    check("reset phasedir", 64'(phasedir), 64'(0));
    check("reset phasestep", 64'(phasestep), 64'(0));
    check("reset phaseloadreg", 64'(phaseloadreg), 64'(0));
    check("reset busy", 64'(rq.busy), 64'(0));
    check("reset done/err", 64'({rq.done, rq.err}), 64'(0));
    check("reset phase_o", 64'(phase), 64'(0));
    check("reset ready", 64'(rq.req_ready), 64'(0));
    reset = 1'b0;
    @(negedge clk);
    check("idle ready", 64'(rq.req_ready), 64'(1));

    for (int unsigned i = 0; i < 9; i++) begin
      lf = vec[i].lf;
      ll = vec[i].ll;
      model_steps(vec[i].sel, vec[i].dir, vec[i].steps);
      issue(vec[i].sel, vec[i].dir, vec[i].steps, vec[i].load);
      complete($sformatf("vec%0d", i), vec[i].sel, vec[i].dir, vec[i].steps, vec[i].load,
               vec[i].exp_done, vec[i].exp_err);
      check($sformatf("vec%0d table phase", i), 64'(phase[vec[i].sel*10 +: 10]),
            64'(TRACK ? vec[i].exp_ph : 0));
    end

    // Request held while unlocked: no accept until lock rises.
    lf = 0; ll = 0;
    @(negedge clk);
    locked = 1'b0;
    rq.req_sel = 2'd2; rq.req_dir = 1'b1; rq.req_steps = 8'd1; rq.req_load = 1'b0;
    rq.req_valid = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("unlocked ready %0d", k), 64'(rq.req_ready), 64'(0));
      check($sformatf("unlocked busy %0d", k), 64'(rq.busy), 64'(0));
    end
    locked = 1'b1;
    #1;
    check("lock raised ready", 64'(rq.req_ready), 64'(1));
    @(posedge clk);
    #1;
    model_steps(2'd2, 1'b1, 1);
    complete("lockwait", 2'd2, 1'b1, 1, 1'b0, 27, 1'b0);

    for (int unsigned i = 0; i < 24; i++) begin
      s  = 2'($urandom);
      dr = 1'($urandom);
      st = $urandom_range(0, 6);
      ld = 1'($urandom);
      lf = $urandom_range(1, 70);
      ll = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 15);
      model_steps(s, dr, st);
      model_done(st, ld, d, e);
      issue(s, dr, st, ld);
      complete($sformatf("rnd%0d", i), s, dr, st, ld, d, e);
    end

    // Reset during the second STEP_HI aborts immediately.
    lf = 0; ll = 0;
    issue(2'd1, 1'b0, 3, 1'b0);
    rise = 0; prev = 1'b0;
    for (int unsigned k = 0; k < 40 && rise < 2; k++) begin
      @(negedge clk);
      rq.req_valid = 1'b0;
      if (phasestep && !prev) rise++;
      prev = phasestep;
    end
    check("abort reached 2nd pulse", 64'(rise), 64'(2));
    reset = 1'b1;
    @(posedge clk);
    #1;
    for (int unsigned ch = 0; ch < 4; ch++) exp_ph[ch] = 0;
    check("abort phasestep", 64'(phasestep), 64'(0));
    check("abort busy", 64'(rq.busy), 64'(0));
    check("abort done", 64'(rq.done), 64'(0));
    check("abort phasesel", 64'(phasesel), 64'(0));
    check("abort phase_o", 64'(phase), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    rise = 0;
    for (int unsigned k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rq.done || rq.busy || phasestep) rise++;
    end
    check("abort no done afterwards", 64'(rise), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
